sensor_cmd_parser: RTL and testbench

Byte-stream command parser directly downstream of `uart_rx`. It consumes received bytes over a valid/ready handshake; its `byte_ready` output drives `uart_rx`'s `sensor_ready`. It assembles fixed-format frames (sync, address, 16-bit data, optional checksum) and presents each complete frame as one register-write command on a valid/ready output port. Malformed or stalled frames are dropped and flagged.

---
 rtl/sensor_cmd_parser.sv | 145 ++++++++++++++
 tb/tb_sensor_cmd_parser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_cmd_parser.sv
// sensor_cmd_parser
// Byte-stream command parser that sits behind uart_rx. It assembles frames
// of the form SYNC, ADDR, DHI, DLO [, CHK] and presents each complete frame
// as one register-write command on a valid/ready port.
//
// Build option: define SENSOR_CMD_CHECKSUM_EN to add the trailing XOR
// checksum byte (CHK = ADDR ^ DHI ^ DLO). When it is not defined, frames
// are 4 bytes long and err_checksum stays 0.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   byte_data/valid      received byte from uart_rx
//   byte_ready           parser can take a byte (to uart_rx sensor_ready)
//   cmd_valid/ready      command handshake
//   cmd_addr, cmd_data   command fields, held stable while cmd_valid=1
//   err_checksum         one-cycle pulse on a bad checksum
//   err_timeout          one-cycle pulse when a frame stalls mid-way
//   cmd_count            delivered commands, wraps at 16 bits
module sensor_cmd_parser #(
    parameter int              DATA_WIDTH     = 8,
    parameter logic [7:0]      SYNC_BYTE      = 8'h55,
    parameter int              TIMEOUT_CYCLES = 34720
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [7:0]            cmd_addr,
    output logic [15:0]           cmd_data,
    output logic                  err_checksum,
    output logic                  err_timeout,
    output logic [15:0]           cmd_count
);

    localparam int GW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef SENSOR_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DHI, S_DLO, S_CHK, S_OUT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DHI, S_DLO, S_OUT} state_t;
`endif

    state_t          state, state_d;
    logic [GW-1:0]   gap;
    logic [7:0]      addr_q, dhi_q;
    logic [7:0]      lo_byte;
    logic            accept, gap_max;
    logic            load_cmd, chk_err, tmo;

    // Gap timer only matters while a frame is partially assembled.
    function automatic logic in_frame(input state_t s);
        return (s != S_IDLE) && (s != S_OUT);
    endfunction

    assign accept  = byte_valid && byte_ready;
    assign gap_max = (gap == GW'(TIMEOUT_CYCLES - 1));

`ifdef SENSOR_CMD_CHECKSUM_EN
    logic [7:0] dlo_q;
    assign lo_byte = dlo_q;
`else
    assign lo_byte = byte_data;
`endif

    always_comb begin
        state_d  = state;
        load_cmd = 1'b0;
        chk_err  = 1'b0;
        tmo      = 1'b0;
        case (state)
            S_IDLE: if (accept && byte_data == SYNC_BYTE) state_d = S_ADDR;
            S_ADDR: if (accept) state_d = S_DHI;
            S_DHI:  if (accept) state_d = S_DLO;
`ifdef SENSOR_CMD_CHECKSUM_EN
            S_DLO:  if (accept) state_d = S_CHK;
            S_CHK: begin
                if (accept) begin
                    if (byte_data == (addr_q ^ dhi_q ^ dlo_q)) begin
                        state_d  = S_OUT;
                        load_cmd = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        chk_err = 1'b1;
                    end
                end
            end
`else
            S_DLO: begin
                if (accept) begin
                    state_d  = S_OUT;
                    load_cmd = 1'b1;
                end
            end
`endif
            S_OUT:  if (cmd_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A byte on the expiry cycle wins, so only time out without one.
        if (in_frame(state) && !accept && gap_max) begin
            state_d = S_IDLE;
            tmo     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            gap          <= '0;
            addr_q       <= '0;
            dhi_q        <= '0;
            byte_ready   <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_addr     <= '0;
            cmd_data     <= '0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            cmd_count    <= '0;
        end else begin
            state        <= state_d;
            byte_ready   <= (state_d != S_OUT);
            cmd_valid    <= (state_d == S_OUT);
            err_checksum <= chk_err;
            err_timeout  <= tmo;
            gap          <= (accept || !in_frame(state_d)) ? '0 : gap + GW'(1);
            if (accept && state == S_ADDR) addr_q <= byte_data;
            if (accept && state == S_DHI)  dhi_q  <= byte_data;
            if (load_cmd) begin
                cmd_addr <= addr_q;
                cmd_data <= {dhi_q, lo_byte};
            end
            if (cmd_valid && cmd_ready) cmd_count <= cmd_count + 16'd1;
        end
    end

`ifdef SENSOR_CMD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                       dlo_q <= '0;
        else if (accept && state == S_DLO) dlo_q <= byte_data;
    end
`endif

endmodule

// File: tb/tb_sensor_cmd_parser.sv
// Bench for sensor_cmd_parser: frame-level reference model (byte queue,
// gap counter, pending command) checked against the DUT every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_sensor_cmd_parser;

    localparam int TMO = 40;
`ifdef SENSOR_CMD_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
    localparam int FL     = 5;
`else
    localparam bit CHK_ON = 1'b0;
    localparam int FL     = 4;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        err_checksum, err_timeout;
    logic [15:0] cmd_count;

    int vec = 0;
    int miss = 0;

    sensor_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .err_checksum(err_checksum), .err_timeout(err_timeout),
        .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  mq[$];
    int          m_gap;
    logic        m_ready, m_valid, m_echk, m_etmo;
    logic [7:0]  m_addr;
    logic [15:0] m_data, m_count;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_gap = 0; m_ready = 0; m_valid = 0; m_echk = 0; m_etmo = 0;
            m_addr = 0; m_data = 0; m_count = 0;
        end else begin
            logic acc;
            acc = byte_valid && m_ready;
            m_echk = 0;
            m_etmo = 0;
            if (m_valid) begin
                if (cmd_ready) begin
                    m_valid = 0;
                    m_count = m_count + 16'd1;
                end
            end else if (acc) begin
                if (mq.size() != 0 || byte_data == 8'h55) mq.push_back(byte_data);
                m_gap = 0;
                if (mq.size() == FL) begin
                    if (!CHK_ON || mq[FL-1] == (mq[1] ^ mq[2] ^ mq[3])) begin
                        m_valid = 1;
                        m_addr  = mq[1];
                        m_data  = {mq[2], mq[3]};
                    end else begin
                        m_echk = 1;
                    end
                    mq.delete();
                end
            end else if (mq.size() != 0) begin
                if (m_gap == TMO - 1) begin
                    m_etmo = 1;
                    m_gap  = 0;
                    mq.delete();
                end else begin
                    m_gap++;
                end
            end
            m_ready = !m_valid;
        end
    end

    always @(negedge clk) begin
        vec++;
        if (byte_ready !== m_ready || cmd_valid !== m_valid || err_checksum !== m_echk ||
            err_timeout !== m_etmo || cmd_count !== m_count ||
            (m_valid && (cmd_addr !== m_addr || cmd_data !== m_data))) begin
            miss++;
            $display("FAIL model @%0t: got rdy=%b vld=%b a=%h d=%h ec=%b et=%b cnt=%0d, want rdy=%b vld=%b a=%h d=%h ec=%b et=%b cnt=%0d",
                     $time, byte_ready, cmd_valid, cmd_addr, cmd_data, err_checksum, err_timeout, cmd_count,
                     m_ready, m_valid, m_addr, m_data, m_echk, m_etmo, m_count);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; returns on the negedge after acceptance.
    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            miss++;
            $display("FAIL send_wait: byte %h not accepted within %0d cycles", b, n);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo);
        send(8'h55); send(a); send(hi); send(lo);
        if (CHK_ON) send(a ^ hi ^ lo);
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hv, k, at;
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("reset_ready", byte_ready, 0);
        chk("reset_valid", cmd_valid, 0);
        chk("reset_addr",  cmd_addr, 0);
        chk("reset_data",  cmd_data, 0);
        chk("reset_count", cmd_count, 0);
        chk("reset_errs",  {err_checksum, err_timeout}, 0);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", byte_ready, 1);

        // basic frame 55 12 AB CD (+74)
        frame(8'h12, 8'hAB, 8'hCD);
        chk("f1_valid", cmd_valid, 1);
        chk("f1_ready_low", byte_ready, 0);
        chk("f1_addr", cmd_addr, 8'h12);
        chk("f1_data", cmd_data, 16'hABCD);
        @(negedge clk);
        chk("f1_count", cmd_count, 1);
        chk("f1_valid_drop", cmd_valid, 0);

        // consumer stall for 100 cycles with a byte pending upstream
        cmd_ready = 1'b0;
        frame(8'h12, 8'hAB, 8'hCD);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        hv = 0;
        repeat (100) begin
            @(negedge clk);
            if (cmd_valid && !byte_ready && cmd_addr == 8'h12 && cmd_data == 16'hABCD) hv++;
        end
        chk("stall_held_cycles", hv, 100);
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("stall_count", cmd_count, 2);
        send(8'h55); send(8'h01); send(8'h02); send(8'h03);
        if (CHK_ON) send(8'h00);
        chk("stall_byte_kept_data", cmd_data, 16'h0203);
        @(negedge clk);
        chk("stall_byte_kept_count", cmd_count, 3);

        // leading junk
        send(8'h00); send(8'hFF);
        frame(8'h12, 8'h34, 8'h56);
        chk("junk_addr", cmd_addr, 8'h12);
        chk("junk_data", cmd_data, 16'h3456);
        idle(1);
        chk("junk_count", cmd_count, 4);

        // bad checksum then good (only meaningful with the feature)
        if (CHK_ON) begin
            send(8'h55); send(8'h01); send(8'h02); send(8'h04);
            send(8'h00);
            chk("bad_chk_pulse", err_checksum, 1);
            chk("bad_chk_no_cmd", cmd_valid, 0);
            frame(8'h01, 8'h02, 8'h04);
            chk("good_chk_data", cmd_data, 16'h0204);
            idle(1);
            chk("good_chk_count", cmd_count, 5);
        end

        // inter-byte timeout
        send(8'h55); send(8'h12);
        at = -1;
        for (k = 1; k <= TMO + 20; k++) begin
            @(negedge clk);
            if (err_timeout && at < 0) at = k;
        end
        chk("timeout_cycle", at, TMO);

        // byte on the expiry cycle wins
        send(8'h55); send(8'h12);
        idle(TMO - 1);
        send(8'hAB);
        chk("expiry_no_err", err_timeout, 0);
        send(8'hCD);
        if (CHK_ON) send(8'h12 ^ 8'hAB ^ 8'hCD);
        chk("expiry_valid", cmd_valid, 1);
        chk("expiry_data", {cmd_addr, cmd_data}, 24'h12ABCD);
        idle(2);

        // reset mid-frame
        send(8'h55); send(8'h12); send(8'hAB);
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("midreset_count", cmd_count, 0);
        chk("midreset_ready", byte_ready, 0);
        chk("midreset_fields", {cmd_valid, cmd_addr, cmd_data}, 0);
        #2 rstn = 1'b1;
        @(negedge clk);
        frame(8'h5A, 8'h55, 8'h01);
        chk("post_reset_data", {cmd_addr, cmd_data}, 24'h5A5501);
        idle(2);
        chk("post_reset_count", cmd_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
